axil_slave_frontend: RTL and testbench



---
 rtl/axil_fe_pkg.sv | 20 ++
 rtl/axil_slave_frontend_if.sv | 38 +++
 rtl/axil_slave_frontend.sv | 143 ++++++++++++++
 tb/tb_axil_slave_frontend.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_fe_pkg.sv
// Shared types and constants for the AXI4-Lite slave front-end.
// The direction encodings are shared with the SDRAM-side consumer.
package axil_fe_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_CAPT,
    WR_PUSH,
    WR_RESP,
    RD_PUSH,
    RD_WAIT,
    RD_POP,
    RD_RESP
  } state_t;

  localparam logic [1:0] RESP_OKAY = 2'b00;
  localparam logic       RW_WRITE  = 1'b1;
  localparam logic       RW_READ   = 1'b0;

endpackage

// File: rtl/axil_slave_frontend_if.sv
// AXI4-Lite bus bundle: AW, W, B, AR and R channels.
// master drives requests and response readies; slave the rest.
interface axil_slave_frontend_if #(
  parameter int SIZE = 32
) ();

  logic [SIZE-1:0] AWADDR;
  logic            AWVALID;
  logic            AWREADY;
  logic [SIZE-1:0] WDATA;
  logic            WVALID;
  logic            WREADY;
  logic [1:0]      BRESP;
  logic            BVALID;
  logic            BREADY;
  logic [SIZE-1:0] ARADDR;
  logic            ARVALID;
  logic            ARREADY;
  logic [SIZE-1:0] RDATA;
  logic [1:0]      RRESP;
  logic            RVALID;
  logic            RREADY;

  modport master (
    output AWADDR, AWVALID, WDATA, WVALID,
    output BREADY, ARADDR, ARVALID, RREADY,
    input  AWREADY, WREADY, BRESP, BVALID,
    input  ARREADY, RDATA, RRESP, RVALID
  );

  modport slave (
    input  AWADDR, AWVALID, WDATA, WVALID,
    input  BREADY, ARADDR, ARVALID, RREADY,
    output AWREADY, WREADY, BRESP, BVALID,
    output ARREADY, RDATA, RRESP, RVALID
  );

endinterface

// File: rtl/axil_slave_frontend.sv
// AXI4-Lite slave front-end: one transaction in flight, pushes
// addr/data/direction into CDC FIFOs, pops read data, answers B/R.
// Ports: AXI_CLK, ARESET (sync, high), axi (slave bus bundle),
// AXIL_* FIFO push/pop strobes and data, FIFO full/empty flags.
module axil_slave_frontend
  import axil_fe_pkg::*;
#(
  parameter int SIZE = 32
) (
  input  logic            AXI_CLK,
  input  logic            ARESET,
  axil_slave_frontend_if.slave axi,
  output logic            AXIL_WR_ADDR_EN,
  output logic [SIZE-1:0] AXIL_WR_ADDR_IN,
  output logic            AXIL_WR_DATA_EN,
  output logic [SIZE-1:0] AXIL_WR_DATA_IN,
  output logic            AXIL_RD_ADDR_EN,
  output logic [SIZE-1:0] AXIL_RD_ADDR_IN,
  output logic            AXIL_RW_EN,
  output logic            AXIL_RW_IN,
  output logic            AXIL_RD_DATA_EN,
  input  logic [SIZE-1:0] AXIL_RD_DATA_OUT,
  input  logic            WADDR_FIFO_FULL,
  input  logic            WDATA_FIFO_FULL,
  input  logic            RADDR_FIFO_FULL,
  input  logic            RW_FIFO_FULL,
  input  logic            RDATA_FIFO_EMPTY
);

  state_t state_q, state_d;

  logic            aw_got_q, w_got_q;
  logic            last_wr_q;
  logic [SIZE-1:0] waddr_q, wdata_q, raddr_q;
  logic [SIZE-1:0] rdata_q;

  logic is_idle, is_capt;
  logic wr_pend, rd_pend;
  logic wr_gnt, rd_gnt;
  logic aw_rdy, w_rdy, ar_rdy;
  logic aw_hs, w_hs, ar_hs;
  logic wr_push, rd_push, rd_pop;

  assign is_idle = (state_q == IDLE);
  assign is_capt = (state_q == WR_CAPT);

  // Round-robin: on a tie, the side not served last wins.
  assign wr_pend = axi.AWVALID | axi.WVALID;
  assign rd_pend = axi.ARVALID;
  assign wr_gnt  = wr_pend & (~rd_pend | ~last_wr_q);
  assign rd_gnt  = rd_pend & ~wr_gnt;

  assign aw_rdy = (is_idle & wr_gnt) | (is_capt & ~aw_got_q);
  assign w_rdy  = (is_idle & wr_gnt) | (is_capt & ~w_got_q);
  assign ar_rdy = is_idle & rd_gnt;

  assign aw_hs = axi.AWVALID & aw_rdy;
  assign w_hs  = axi.WVALID & w_rdy;
  assign ar_hs = axi.ARVALID & ar_rdy;

  assign wr_push = (state_q == WR_PUSH) & ~WADDR_FIFO_FULL
                 & ~WDATA_FIFO_FULL & ~RW_FIFO_FULL;
  assign rd_push = (state_q == RD_PUSH) & ~RADDR_FIFO_FULL
                 & ~RW_FIFO_FULL;
  assign rd_pop  = (state_q == RD_WAIT) & ~RDATA_FIFO_EMPTY;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (wr_gnt) begin
          state_d = (aw_hs & w_hs) ? WR_PUSH : WR_CAPT;
        end else if (ar_hs) begin
          state_d = RD_PUSH;
        end
      end
      WR_CAPT: begin
        if ((aw_got_q | aw_hs) & (w_got_q | w_hs)) begin
          state_d = WR_PUSH;
        end
      end
      WR_PUSH: if (wr_push) state_d = WR_RESP;
      WR_RESP: if (axi.BREADY) state_d = IDLE;
      RD_PUSH: if (rd_push) state_d = RD_WAIT;
      RD_WAIT: if (rd_pop) state_d = RD_POP;
      RD_POP:  state_d = RD_RESP;
      RD_RESP: if (axi.RREADY) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge AXI_CLK) begin
    if (ARESET) begin
      state_q   <= IDLE;
      aw_got_q  <= 1'b0;
      w_got_q   <= 1'b0;
      last_wr_q <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
      raddr_q   <= '0;
      rdata_q   <= '0;
    end else begin
      state_q <= state_d;
      if (aw_hs) waddr_q <= axi.AWADDR;
      if (w_hs)  wdata_q <= axi.WDATA;
      if (ar_hs) raddr_q <= axi.ARADDR;
      if (wr_push) begin
        aw_got_q <= 1'b0;
        w_got_q  <= 1'b0;
      end else begin
        if (aw_hs) aw_got_q <= 1'b1;
        if (w_hs)  w_got_q  <= 1'b1;
      end
      if (is_idle & wr_gnt) begin
        last_wr_q <= 1'b1;
      end else if (ar_hs) begin
        last_wr_q <= 1'b0;
      end
      // FIFO output is valid the cycle after the pop.
      if (state_q == RD_POP) rdata_q <= AXIL_RD_DATA_OUT;
    end
  end

  assign axi.AWREADY = aw_rdy;
  assign axi.WREADY  = w_rdy;
  assign axi.ARREADY = ar_rdy;
  assign axi.BVALID  = (state_q == WR_RESP);
  assign axi.BRESP   = RESP_OKAY;
  assign axi.RVALID  = (state_q == RD_RESP);
  assign axi.RRESP   = RESP_OKAY;
  assign axi.RDATA   = rdata_q;

  assign AXIL_WR_ADDR_EN = wr_push;
  assign AXIL_WR_DATA_EN = wr_push;
  assign AXIL_RD_ADDR_EN = rd_push;
  assign AXIL_RW_EN      = wr_push | rd_push;
  assign AXIL_RW_IN      = (state_q == WR_PUSH) ? RW_WRITE : RW_READ;
  assign AXIL_RD_DATA_EN = rd_pop;
  assign AXIL_WR_ADDR_IN = waddr_q;
  assign AXIL_WR_DATA_IN = wdata_q;
  assign AXIL_RD_ADDR_IN = raddr_q;

endmodule

// File: tb/tb_axil_slave_frontend.sv
// Directed bench for axil_slave_frontend.
// Stubs the FIFO flags by hand and checks each step.
module tb_axil_slave_frontend;

  logic clk = 1'b0;
  logic rst;

  logic        wr_addr_en, wr_data_en, rd_addr_en;
  logic        rw_en, rw_in, rd_data_en;
  logic [31:0] wr_addr_in, wr_data_in, rd_addr_in;
  logic [31:0] rd_data_out;
  logic        waddr_full, wdata_full, raddr_full;
  logic        rw_full, rdata_empty;

  int n_chk = 0;
  int n_pass = 0;

  axil_slave_frontend_if #(.SIZE(32)) bus ();

  axil_slave_frontend #(.SIZE(32)) dut (
    .AXI_CLK          (clk),
    .ARESET           (rst),
    .axi              (bus),
    .AXIL_WR_ADDR_EN  (wr_addr_en),
    .AXIL_WR_ADDR_IN  (wr_addr_in),
    .AXIL_WR_DATA_EN  (wr_data_en),
    .AXIL_WR_DATA_IN  (wr_data_in),
    .AXIL_RD_ADDR_EN  (rd_addr_en),
    .AXIL_RD_ADDR_IN  (rd_addr_in),
    .AXIL_RW_EN       (rw_en),
    .AXIL_RW_IN       (rw_in),
    .AXIL_RD_DATA_EN  (rd_data_en),
    .AXIL_RD_DATA_OUT (rd_data_out),
    .WADDR_FIFO_FULL  (waddr_full),
    .WDATA_FIFO_FULL  (wdata_full),
    .RADDR_FIFO_FULL  (raddr_full),
    .RW_FIFO_FULL     (rw_full),
    .RDATA_FIFO_EMPTY (rdata_empty)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %h want %h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  int       pops;
  int       n_g;
  logic     got;
  logic     both;
  logic [3:0] seq;

  initial begin
    rst = 1'b1;
    bus.AWADDR = '0; bus.AWVALID = 0;
    bus.WDATA = '0;  bus.WVALID = 0;
    bus.BREADY = 0;
    bus.ARADDR = '0; bus.ARVALID = 0;
    bus.RREADY = 0;
    rd_data_out = '0;
    waddr_full = 0; wdata_full = 0;
    raddr_full = 0; rw_full = 0;
    rdata_empty = 1;
    repeat (2) cyc();
    rst = 1'b0;
    #1;
    chk("rst_awready", bus.AWREADY, 0);
    chk("rst_wready", bus.WREADY, 0);
    chk("rst_arready", bus.ARREADY, 0);
    chk("rst_bvalid", bus.BVALID, 0);
    chk("rst_rvalid", bus.RVALID, 0);
    chk("rst_rdata", bus.RDATA, 0);
    chk("rst_bresp", bus.BRESP, 0);
    chk("rst_rresp", bus.RRESP, 0);
    chk("rst_ens", {wr_addr_en, wr_data_en, rd_addr_en,
                    rw_en, rd_data_en}, 0);

    // Same-cycle AW and W.
    bus.AWADDR = 32'h10; bus.AWVALID = 1;
    bus.WDATA = 32'hDEADBEEF; bus.WVALID = 1;
    #1;
    chk("t1_awready", bus.AWREADY, 1);
    chk("t1_wready", bus.WREADY, 1);
    chk("t1_arready", bus.ARREADY, 0);
    cyc();
    bus.AWVALID = 0; bus.WVALID = 0;
    #1;
    chk("t1_ens", {wr_addr_en, wr_data_en, rw_en}, 3'b111);
    chk("t1_rw_in", rw_in, 1);
    chk("t1_addr", wr_addr_in, 32'h10);
    chk("t1_data", wr_data_in, 32'hDEADBEEF);
    chk("t1_bvalid_early", bus.BVALID, 0);
    cyc();
    chk("t1_bvalid", bus.BVALID, 1);
    chk("t1_bresp", bus.BRESP, 0);
    chk("t1_en_off", {wr_addr_en, wr_data_en, rw_en}, 0);
    cyc();
    chk("t1_bvalid_hold", bus.BVALID, 1);
    bus.BREADY = 1;
    cyc();
    bus.BREADY = 0;
    #1;
    chk("t1_bvalid_done", bus.BVALID, 0);

    // W three cycles ahead of AW.
    bus.WDATA = 32'hCAFEF00D; bus.WVALID = 1;
    #1;
    chk("t2_wready", bus.WREADY, 1);
    cyc();
    bus.WVALID = 0;
    #1;
    chk("t2_wready_capt", bus.WREADY, 0);
    chk("t2_awready_capt", bus.AWREADY, 1);
    for (int i = 0; i < 2; i++) begin
      chk("t2_no_push", {wr_addr_en, rw_en}, 0);
      cyc();
    end
    chk("t2_no_push", {wr_addr_en, rw_en}, 0);
    bus.AWADDR = 32'h20; bus.AWVALID = 1;
    cyc();
    bus.AWVALID = 0;
    #1;
    chk("t2_ens", {wr_addr_en, wr_data_en, rw_en}, 3'b111);
    chk("t2_addr", wr_addr_in, 32'h20);
    chk("t2_data", wr_data_in, 32'hCAFEF00D);
    cyc();
    chk("t2_single_push", {wr_addr_en, rw_en}, 0);
    bus.BREADY = 1;
    cyc();
    bus.BREADY = 0;

    // Read with data arriving 10 cycles late.
    rd_data_out = 32'h12345678;
    bus.ARADDR = 32'h40; bus.ARVALID = 1;
    #1;
    chk("t3_arready", bus.ARREADY, 1);
    chk("t3_awready", bus.AWREADY, 0);
    cyc();
    bus.ARVALID = 0;
    #1;
    chk("t3_ens", {rd_addr_en, rw_en}, 2'b11);
    chk("t3_rw_in", rw_in, 0);
    chk("t3_addr", rd_addr_in, 32'h40);
    chk("t3_no_wr", wr_addr_en, 0);
    cyc();
    pops = 0;
    got = 0;
    for (int i = 0; i < 30 && !got; i++) begin
      rdata_empty = (i < 10) || (pops != 0);
      #1;
      if (rd_data_en) pops++;
      if (bus.RVALID) got = 1;
      else cyc();
    end
    rdata_empty = 1;
    chk("t3_rvalid_seen", got, 1);
    chk("t3_pops", pops, 1);
    chk("t3_rdata", bus.RDATA, 32'h12345678);
    chk("t3_rresp", bus.RRESP, 0);
    cyc();
    chk("t3_rvalid_hold", bus.RVALID, 1);
    chk("t3_rdata_hold", bus.RDATA, 32'h12345678);
    bus.RREADY = 1;
    cyc();
    bus.RREADY = 0;
    #1;
    chk("t3_rvalid_done", bus.RVALID, 0);

    // Write-address FIFO full for 5 cycles in WR_PUSH.
    waddr_full = 1;
    bus.AWADDR = 32'h30; bus.AWVALID = 1;
    bus.WDATA = 32'h0BADF00D; bus.WVALID = 1;
    cyc();
    bus.AWVALID = 0; bus.WVALID = 0;
    for (int j = 0; j < 5; j++) begin
      #1;
      chk("t4_stall", {wr_addr_en, wr_data_en, rw_en}, 0);
      cyc();
    end
    waddr_full = 0;
    #1;
    chk("t4_push", {wr_addr_en, wr_data_en, rw_en}, 3'b111);
    chk("t4_addr", wr_addr_in, 32'h30);
    chk("t4_data", wr_data_in, 32'h0BADF00D);
    cyc();
    chk("t4_bvalid", bus.BVALID, 1);
    bus.BREADY = 1;
    cyc();
    bus.BREADY = 0;

    // Reset while in RD_WAIT.
    bus.ARADDR = 32'h44; bus.ARVALID = 1;
    cyc();
    bus.ARVALID = 0;
    cyc();
    chk("t5_wait_no_pop", rd_data_en, 0);
    rst = 1;
    cyc();
    rst = 0;
    #1;
    chk("t5_rvalid", bus.RVALID, 0);
    chk("t5_bvalid", bus.BVALID, 0);
    chk("t5_rdata", bus.RDATA, 0);
    chk("t5_readys", {bus.AWREADY, bus.WREADY, bus.ARREADY}, 0);
    chk("t5_ens", {wr_addr_en, wr_data_en, rd_addr_en,
                   rw_en, rd_data_en}, 0);

    // All three valids held: write first, then alternate.
    bus.AWADDR = 32'h80; bus.AWVALID = 1;
    bus.WDATA = 32'h55AA55AA; bus.WVALID = 1;
    bus.ARADDR = 32'h90; bus.ARVALID = 1;
    bus.BREADY = 1; bus.RREADY = 1;
    rdata_empty = 0;
    #1;
    n_g = 0;
    seq = '0;
    both = 0;
    for (int i = 0; i < 80 && n_g < 4; i++) begin
      if (bus.AWREADY && bus.ARREADY) both = 1;
      if (bus.AWREADY) begin
        seq[n_g] = 1'b1;
        n_g++;
      end else if (bus.ARREADY) begin
        seq[n_g] = 1'b0;
        n_g++;
      end
      cyc();
    end
    bus.AWVALID = 0; bus.WVALID = 0; bus.ARVALID = 0;
    chk("t6_grants", n_g, 4);
    chk("t6_order", seq, 4'b0101);
    chk("t6_never_both", both, 0);
    chk("t6_wr_addr", wr_addr_in, 32'h80);
    chk("t6_wr_data", wr_data_in, 32'h55AA55AA);
    chk("t6_rd_addr", rd_addr_in, 32'h90);
    repeat (8) cyc();
    chk("t6_bvalid_idle", bus.BVALID, 0);
    chk("t6_rvalid_idle", bus.RVALID, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
